dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 159 +++++++++++++++
 tb/tb_dmem_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - handshaked data-memory responder with programmable wait states
//
// Target end of the core's data-memory port. One word request is accepted at a
// time (req && ready), WAIT_CYCLES wait states follow, then ack pulses for one
// cycle with rdata/err. Misaligned or out-of-range addresses complete with
// err=1, rdata=0 and never touch storage.
//
// Ports:
//   clock  - single clock, rising edge
//   reset  - synchronous, active-high
//   req    - request valid, sampled only while ready=1
//   we     - 1 = write, 0 = read (captured with req)
//   addr   - byte address, word index addr[31:2] (captured with req)
//   wdata  - write data (captured with req)
//   ready  - high only while idle
//   ack    - one-cycle completion pulse
//   rdata  - read result, valid with ack for a read, held until next completion
//   err    - error flag, valid with ack, held until next completion

module dmem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;

    logic          cap_we;
    logic [31:0]   cap_addr;
    logic [31:0]   cap_wdata;

    logic          accept;
    logic          enter_done;
    logic          txn_we;
    logic [31:0]   txn_addr;
    logic [31:0]   txn_wdata;
    logic          txn_err;
    logic [IW-1:0] txn_idx;

    logic [31:0]   mem [DEPTH];

    assign accept = (state == S_IDLE) && req;

    // With zero wait states the accept edge is also the completion edge, so the
    // transaction must be taken straight from the inputs; otherwise from the
    // captured copy, which isolates us from requester changes after accept.
    always_comb begin
        if (state == S_IDLE) begin
            txn_we    = we;
            txn_addr  = addr;
            txn_wdata = wdata;
        end else begin
            txn_we    = cap_we;
            txn_addr  = cap_addr;
            txn_wdata = cap_wdata;
        end
    end

    // No wrap modulo DEPTH: the full word index is range-checked.
    assign txn_err = (txn_addr[1:0] != 2'b00) || (txn_addr[31:2] >= DEPTH_W);
    assign txn_idx = txn_addr[IW+1:2];

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_BUSY;
                        count_nxt = CW'(WAIT_CYCLES);
                    end
                end
            end
            S_BUSY: begin
                count_nxt = count - CW'(1);
                // Leave on the edge where the counter reaches zero.
                if (count <= CW'(1)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                count_nxt = '0;
            end
        endcase
    end

    assign enter_done = (state_nxt == S_DONE) && (state != S_DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            count     <= '0;
            ready     <= 1'b1;
            ack       <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            // Outputs are registered copies of the next-state decode.
            ready <= (state_nxt == S_IDLE);
            ack   <= (state_nxt == S_DONE);
            if (accept) begin
                cap_we    <= we;
                cap_addr  <= addr;
                cap_wdata <= wdata;
            end
            if (enter_done) begin
                err <= txn_err;
                if (txn_err) begin
                    rdata <= '0;
                end else if (!txn_we) begin
                    rdata <= mem[txn_idx];
                end
            end
        end
    end

    // Storage has no reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge clock) begin
        if (!reset && enter_done && txn_we && !txn_err) begin
            mem[txn_idx] <= txn_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder
//
// Two instances share clock/reset: index 0 with WAIT_CYCLES=2, index 1 with
// WAIT_CYCLES=0. A word-array reference model predicts ack timing, err and rdata.

module tb_dmem_responder;

    localparam int DEPTH = 256;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_v   [2];
    logic        we_v    [2];
    logic [31:0] addr_v  [2];
    logic [31:0] wdata_v [2];

    logic        ready0, ack0, err0;
    logic        ready1, ack1, err1;
    logic [31:0] rdata0, rdata1;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] ref_mem      [2][DEPTH];
    bit          ref_valid    [2][DEPTH];
    logic [31:0] ref_rdata    [2];
    bit          ref_rd_known [2];
    bit          ref_err      [2];

    always #5 clock = ~clock;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut (
        .clock (clock),
        .reset (reset),
        .req   (req_v[0]),
        .we    (we_v[0]),
        .addr  (addr_v[0]),
        .wdata (wdata_v[0]),
        .ready (ready0),
        .ack   (ack0),
        .rdata (rdata0),
        .err   (err0)
    );

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clock (clock),
        .reset (reset),
        .req   (req_v[1]),
        .we    (we_v[1]),
        .addr  (addr_v[1]),
        .wdata (wdata_v[1]),
        .ready (ready1),
        .ack   (ack1),
        .rdata (rdata1),
        .err   (err1)
    );

    function automatic int wait_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic logic get_ready(input int d);
        return (d == 0) ? ready0 : ready1;
    endfunction

    function automatic logic get_ack(input int d);
        return (d == 0) ? ack0 : ack1;
    endfunction

    function automatic logic get_err(input int d);
        return (d == 0) ? err0 : err1;
    endfunction

    function automatic logic [31:0] get_rdata(input int d);
        return (d == 0) ? rdata0 : rdata1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            ref_rdata[d]    = 32'h0;
            ref_rd_known[d] = 1'b1;
            ref_err[d]      = 1'b0;
        end
    endtask

    // Called one time unit after a rising edge with the instance idle.
    // Returns one time unit after the edge that brings it back to idle.
    task automatic txn(input int d, input bit w, input logic [31:0] a,
                       input logic [31:0] wd, input bit garble);
        bit          exp_err;
        bit          chk_rd;
        logic [31:0] exp_rd;
        int unsigned widx;
        int          last;

        widx    = a >> 2;
        exp_err = (a[1:0] != 2'b00) || (widx >= DEPTH);
        if (exp_err) begin
            exp_rd = 32'h0;
            chk_rd = 1'b1;
        end else if (w) begin
            exp_rd = ref_rdata[d];
            chk_rd = ref_rd_known[d];
        end else begin
            exp_rd = ref_mem[d][widx];
            chk_rd = ref_valid[d][widx];
        end
        last = wait_of(d) + 1;

        check($sformatf("ready_before_accept[%0d]", d), get_ready(d), 1'b1);
        req_v[d]   = 1'b1;
        we_v[d]    = w;
        addr_v[d]  = a;
        wdata_v[d] = wd;
        tick();
        for (int c = 1; c <= last; c++) begin
            check($sformatf("ready_low[%0d] c%0d", d, c), get_ready(d), 1'b0);
            check($sformatf("ack[%0d] c%0d", d, c), get_ack(d), (c == last));
            if (c == last) begin
                check($sformatf("err[%0d] a=%h", d, a), get_err(d), exp_err);
                if (chk_rd)
                    check($sformatf("rdata[%0d] a=%h", d, a), get_rdata(d), exp_rd);
            end
            if (garble) begin
                we_v[d]    = $urandom_range(0, 1);
                addr_v[d]  = $urandom;
                wdata_v[d] = $urandom;
            end
            tick();
        end
        req_v[d] = 1'b0;
        check($sformatf("ready_back[%0d]", d), get_ready(d), 1'b1);
        check($sformatf("ack_drop[%0d]", d), get_ack(d), 1'b0);
        check($sformatf("err_hold[%0d]", d), get_err(d), exp_err);

        ref_err[d] = exp_err;
        if (exp_err || !w) begin
            ref_rdata[d]    = exp_rd;
            ref_rd_known[d] = chk_rd;
        end
        if (!exp_err && w) begin
            ref_mem[d][widx]   = wd;
            ref_valid[d][widx] = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          d;
        int          kind;

        for (int i = 0; i < 2; i++) begin
            req_v[i]   = 1'b1;
            we_v[i]    = 1'b1;
            addr_v[i]  = 32'h10;
            wdata_v[i] = 32'hFFFF_0000;
            for (int j = 0; j < DEPTH; j++) ref_valid[i][j] = 1'b0;
        end
        model_reset();

        // Reset held two cycles with req high: no accept, no ack.
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            check("reset_ack0", ack0, 1'b0);
            check("reset_ack1", ack1, 1'b0);
        end
        req_v[0] = 1'b0;
        req_v[1] = 1'b0;
        reset    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_ready[%0d]", i), get_ready(i), 1'b1);
            check($sformatf("rst_rdata[%0d]", i), get_rdata(i), 32'h0);
            check($sformatf("rst_err[%0d]", i), get_err(i), 1'b0);
        end

        // Write then read, WAIT_CYCLES=2.
        txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
        txn(0, 1'b0, 32'h10, 32'h0, 1'b1);

        // Error paths.
        txn(0, 1'b0, 32'h11, 32'h0, 1'b0);
        txn(0, 1'b1, 32'h0, 32'h0BAD_F00D, 1'b0);
        txn(0, 1'b1, 32'h400, 32'h0000_1234, 1'b0);
        txn(0, 1'b0, 32'h0, 32'h0, 1'b0);

        // Back-to-back on the zero-wait instance with inputs scrambled mid-transaction.
        txn(1, 1'b1, 32'h0, 32'h1111_0000, 1'b1);
        txn(1, 1'b1, 32'h4, 32'h2222_0004, 1'b1);
        txn(1, 1'b1, 32'h8, 32'h3333_0008, 1'b1);
        txn(1, 1'b0, 32'h0, 32'h0, 1'b1);
        txn(1, 1'b0, 32'h4, 32'h0, 1'b1);
        txn(1, 1'b0, 32'h8, 32'h0, 1'b1);

        // Reset in the middle of a write aborts it.
        txn(0, 1'b1, 32'h20, 32'h1111_1111, 1'b0);
        req_v[0]   = 1'b1;
        we_v[0]    = 1'b1;
        addr_v[0]  = 32'h20;
        wdata_v[0] = 32'hCAFE_F00D;
        tick();
        check("midrst_busy", ready0, 1'b0);
        req_v[0] = 1'b0;
        reset    = 1'b1;
        tick();
        check("midrst_ack_c2", ack0, 1'b0);
        reset = 1'b0;
        model_reset();
        tick();
        check("midrst_ack_c3", ack0, 1'b0);
        check("midrst_ready", ready0, 1'b1);
        check("midrst_rdata", rdata0, 32'h0);
        txn(0, 1'b0, 32'h20, 32'h0, 1'b0);

        // Upper boundary.
        txn(0, 1'b1, 32'h3FC, 32'hA5A5_A5A5, 1'b0);
        txn(0, 1'b0, 32'h3FC, 32'h0, 1'b0);
        txn(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0);
        txn(1, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0);

        // Randomized mix over both instances.
        for (int n = 0; n < 80; n++) begin
            d    = $urandom_range(0, 1);
            kind = $urandom_range(0, 9);
            case (kind)
                6:       a = 32'h3FC;
                7:       a = 32'h400 + ($urandom_range(0, 255) << 2);
                8:       a = ($urandom_range(0, 15) << 2) | $urandom_range(1, 3);
                9:       a = 32'hFFFF_FFFC;
                default: a = $urandom_range(0, 15) << 2;
            endcase
            txn(d, $urandom_range(0, 1), a, $urandom, $urandom_range(0, 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
